// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared size encodings, responder FSM states and default geometry.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int DEF_DEPTH   = 128;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
        return sz == SZ_H ? off[0] : sz == SZ_W ? |off[1:0] : sz == SZ_D ? |off : 1'b0;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-merge into a doubleword and load extract/extend from it.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [63:0] dw,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] new_dw,
    output logic [63:0] rdata
);

    logic [7:0]  lane_mask;
    logic [7:0]  byte_mask;
    logic [63:0] st_sh;
    logic [63:0] ld_sh;

    always_comb begin
        lane_mask = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
        byte_mask = lane_mask << offset;
        st_sh     = wdata << {offset, 3'b000};
        ld_sh     = dw >> {offset, 3'b000};
        rdata     = size == SZ_B ? {{56{~is_unsigned & ld_sh[7]}}, ld_sh[7:0]} :
                    size == SZ_H ? {{48{~is_unsigned & ld_sh[15]}}, ld_sh[15:0]} :
                    size == SZ_W ? {{32{~is_unsigned & ld_sh[31]}}, ld_sh[31:0]} : ld_sh;
    end

    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign new_dw[8*i +: 8] = byte_mask[i] ? st_sh[8*i +: 8] : dw[8*i +: 8];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-outstanding data memory with byte/half/word/dword access.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    state_t      state, next_state;
    logic [2:0]  cnt;
    logic        we_q, uns_q;
    logic [63:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [63:0] mem [DEPTH];
    logic [63:0] new_dw, ld_data;
    logic        fire, err;
    logic [IW-1:0] idx;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign fire      = state == BUSY && cnt == 3'd0;
    assign err       = misaligned(addr_q[2:0], size_q) || addr_q[63:3] >= 61'(DEPTH);
    assign idx       = addr_q[3 +: IW];

    mem_lane_align u_align (
        .dw          (mem[idx]),
        .wdata       (wdata_q),
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .new_dw      (new_dw),
        .rdata       (ld_data)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next_state;

    always_comb begin
        next_state = state;
        if (state == IDLE && req_valid) next_state = BUSY;
        if (fire) next_state = RESP;
        if (state == RESP && rsp_ready) next_state = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= 3'd0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            size_q    <= SZ_B;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cnt     <= 3'(LATENCY - 1);
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
            end
            if (state == BUSY && cnt != 3'd0) cnt <= cnt - 3'd1;
            if (fire) begin
                rsp_rdata <= (err || we_q) ? 64'd0 : ld_data;
                rsp_err   <= err;
            end
        end
    end

    // Storage is deliberately unreset so contents survive a reset pulse.
    always_ff @(posedge clock)
        if (fire && we_q && !err) mem[idx] <= new_dw;

endmodule
